// File: rtl/debug_dump_sequencer_pkg.sv
// Shared types and constants for the post-halt debug dump sequencer.
// Optional feature macro: DUMP_CYCLE_COUNT_EN adds a cycle-count word after the PC.
package debug_dump_sequencer_pkg;

  localparam int DUMP_NB_DATA     = 32;
  localparam int DUMP_NB_REG      = 5;
  localparam int DUMP_NB_ADDR     = 7;
  localparam int DUMP_N_MEM_WORDS = 16;
  localparam int BYTES_PER_WORD   = DUMP_NB_DATA / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_SEND,
    ST_WAIT_TX,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    WC_PC,
    WC_CYC,
    WC_REG,
    WC_MEM
  } word_class_e;

`ifdef DUMP_CYCLE_COUNT_EN
  localparam int CYC_WORDS = 1;
`else
  localparam int CYC_WORDS = 0;
`endif

  function automatic int dump_words(input int n_regs, input int n_mem);
    return 1 + CYC_WORDS + n_regs + n_mem;
  endfunction

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// Bus between the dump sequencer (master) and the debug read ports / UART TX (slave).
// Byte handshake: o_tx_start pulses once per byte with o_tx_data valid; o_tx_data holds until i_tx_done, which completes the byte.
interface debug_dump_sequencer_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_ADDR = 7
);
  logic               i_start;
  logic               i_run;
  logic [NB_ADDR-1:0] i_pc_value;
  logic [NB_DATA-1:0] i_br_data;
  logic [NB_DATA-1:0] i_dm_data;
  logic               i_tx_done;
  logic [NB_REG-1:0]  o_br_addr;
  logic               o_br_read;
  logic [NB_ADDR-1:0] o_dm_addr;
  logic               o_dm_read;
  logic [7:0]         o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_done;

  modport master (
    input  i_start, i_run, i_pc_value, i_br_data, i_dm_data, i_tx_done,
    output o_br_addr, o_br_read, o_dm_addr, o_dm_read, o_tx_data, o_tx_start, o_busy, o_done
  );

  modport slave (
    output i_start, i_run, i_pc_value, i_br_data, i_dm_data, i_tx_done,
    input  o_br_addr, o_br_read, o_dm_addr, o_dm_read, o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/debug_dump_sequencer_word_serializer.sv
// Holds one captured word and presents it a byte at a time, LSB first.
// last_o flags that the byte currently presented is the final byte of the word.
module debug_dump_sequencer_word_serializer #(
  parameter int NB_DATA = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [NB_DATA-1:0] word_i,
  output logic [7:0]         byte_o,
  output logic               last_o
);
  localparam int BPW = NB_DATA / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic [BW-1:0]      idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load_i) begin
      shreg_d = word_i;
      idx_d   = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 8;
      idx_d   = idx_q + BW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_o = shreg_q[7:0];
  assign last_o = (idx_q == BW'(BPW - 1));

endmodule

// File: rtl/debug_dump_sequencer.sv
// Post-halt dump: PC, [cycle count], register file, data memory, streamed to UART TX.
// Optional feature macro: DUMP_CYCLE_COUNT_EN (cycle counter word sent after the PC).
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int NB_DATA     = DUMP_NB_DATA,
  parameter int NB_REG      = DUMP_NB_REG,
  parameter int NB_ADDR     = DUMP_NB_ADDR,
  parameter int N_MEM_WORDS = DUMP_N_MEM_WORDS
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  debug_dump_sequencer_if.master bus,
  output state_e                 o_dbg_state
);
  localparam int N_REGS   = 2 ** NB_REG;
  localparam int N_WORDS  = dump_words(N_REGS, N_MEM_WORDS);
  localparam int REG_BASE = 1 + CYC_WORDS;
  localparam int MEM_BASE = REG_BASE + N_REGS;
  localparam int IW       = $clog2(N_WORDS + 1);
  localparam int WW       = (IW > NB_ADDR) ? IW + 1 : NB_ADDR + 1;

  state_e             state_q, state_d;
  logic [WW-1:0]      word_q, word_d;
  logic [NB_REG-1:0]  br_addr_q, br_addr_d;
  logic [NB_ADDR-1:0] dm_addr_q, dm_addr_d;
  logic [WW-1:0]      reg_off, mem_off;
  word_class_e        wclass;
  logic [NB_DATA-1:0] cyc_word, cap_word;
  logic               busy;
  logic               ser_load, ser_shift, ser_last;
  logic [7:0]         ser_byte;
  logic               unused_off;

  assign busy = (state_q != ST_IDLE) && (state_q != ST_FINISH);

`ifdef DUMP_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  // Counts only while the pipeline runs outside a dump; sticks at all-ones.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cyc_q <= '0;
    end else if (bus.i_run && !busy && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cyc_word = NB_DATA'(cyc_q);
`else
  logic unused_run;
  assign unused_run = bus.i_run;
  assign cyc_word   = '0;
`endif

  assign reg_off    = word_q - WW'(REG_BASE);
  assign mem_off    = word_q - WW'(MEM_BASE);
  assign unused_off = ^{reg_off[WW-1:NB_REG], mem_off[WW-1:NB_ADDR]};

  always_comb begin
    wclass = WC_MEM;
    if (word_q == '0) begin
      wclass = WC_PC;
    end else if (word_q < WW'(REG_BASE)) begin
      wclass = WC_CYC;
    end else if (word_q < WW'(MEM_BASE)) begin
      wclass = WC_REG;
    end
  end

  always_comb begin
    case (wclass)
      WC_PC:   cap_word = NB_DATA'(bus.i_pc_value);
      WC_CYC:  cap_word = cyc_word;
      WC_REG:  cap_word = bus.i_br_data;
      default: cap_word = bus.i_dm_data;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    br_addr_d      = br_addr_q;
    dm_addr_d      = dm_addr_q;
    ser_load       = 1'b0;
    ser_shift      = 1'b0;
    bus.o_tx_start = 1'b0;
    bus.o_done     = 1'b0;
    bus.o_br_read  = 1'b0;
    bus.o_dm_read  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_FETCH;
          word_d  = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_CAPTURE;
        if (wclass == WC_REG) begin
          bus.o_br_read = 1'b1;
          br_addr_d     = reg_off[NB_REG-1:0];
        end
        if (wclass == WC_MEM) begin
          bus.o_dm_read = 1'b1;
          dm_addr_d     = mem_off[NB_ADDR-1:0];
        end
      end
      ST_CAPTURE: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        bus.o_tx_start = 1'b1;
        state_d        = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.i_tx_done) begin
          ser_shift = 1'b1;
          if (!ser_last) begin
            state_d = ST_SEND;
          end else if (word_q == WW'(N_WORDS - 1)) begin
            state_d = ST_FINISH;
          end else begin
            word_d  = word_q + WW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_FINISH: begin
        bus.o_done = 1'b1;
        word_d     = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      br_addr_q <= '0;
      dm_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      br_addr_q <= br_addr_d;
      dm_addr_q <= dm_addr_d;
    end
  end

  debug_dump_sequencer_word_serializer #(
    .NB_DATA(NB_DATA)
  ) u_ser (
    .clk_i  (i_clock),
    .rst_i  (i_reset),
    .load_i (ser_load),
    .shift_i(ser_shift),
    .word_i (cap_word),
    .byte_o (ser_byte),
    .last_o (ser_last)
  );

  // Addresses follow the fetch-cycle value and hold it until the next fetch of that class.
  assign bus.o_br_addr = br_addr_d;
  assign bus.o_dm_addr = dm_addr_d;
  assign bus.o_tx_data = ser_byte;
  assign bus.o_busy    = busy;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: byte stream, handshake holds, resets and read ports.
module tb_debug_dump_sequencer;
  import debug_dump_sequencer_pkg::*;

  localparam int N_REGS   = 32;
  localparam int N_MEM    = 16;
  localparam int N_WORDS  = 1 + CYC_WORDS + N_REGS + N_MEM;
  localparam int N_BYTES  = 4 * N_WORDS;
  localparam int REG_BASE = 1 + CYC_WORDS;
  localparam int MEM_BASE = REG_BASE + N_REGS;
  localparam int BUDGET   = 8000;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int br_hits[N_REGS];
  int dm_hits[N_MEM];
  int ndone, restart_err, unstable_err, overlap;
  logic busy_after_start, done_busy;

  debug_dump_sequencer_if dif ();

  debug_dump_sequencer dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .bus        (dif),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Read-port models: one-cycle latency, garbage when no read was issued.
  always @(posedge clk) begin
    if (dif.o_br_read) dif.i_br_data <= 32'(dif.o_br_addr);
    else               dif.i_br_data <= 32'hDEAD_BEEF;
    if (dif.o_dm_read) dif.i_dm_data <= 32'hA0 + 32'(dif.o_dm_addr);
    else               dif.i_dm_data <= 32'hBAAD_F00D;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input logic [6:0] pc, input logic [31:0] cyc);
    logic [31:0] w;
    exp_q.delete();
    for (int k = 0; k < N_WORDS; k++) begin
      if (k == 0)             w = 32'(pc);
      else if (k < REG_BASE)  w = cyc;
      else if (k < MEM_BASE)  w = 32'(k - REG_BASE);
      else                    w = 32'hA0 + 32'(k - MEM_BASE);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  // Drives one dump: UART answers tx_delay cycles after each start (stall_len for byte stall_at).
  task automatic run_dump(input int tx_delay, input int stall_at, input int stall_len,
                          input bit noise, input int reset_at, output bit timed_out);
    int cd;
    bit fin;
    logic [7:0] last_byte;
    got_q.delete();
    ndone = 0; restart_err = 0; unstable_err = 0; overlap = 0; done_busy = 1'b1;
    foreach (br_hits[i]) br_hits[i] = 0;
    foreach (dm_hits[i]) dm_hits[i] = 0;
    cd = 0; fin = 0; last_byte = 8'h00; timed_out = 1'b1;
    dif.i_start = 1'b1;
    tick();
    dif.i_start = 1'b0;
    busy_after_start = dif.o_busy;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (dif.o_br_read) br_hits[dif.o_br_addr]++;
      if (dif.o_dm_read && int'(dif.o_dm_addr) < N_MEM) dm_hits[dif.o_dm_addr]++;
      if (dif.o_br_read && dif.o_dm_read) overlap++;
      if (cd > 0) begin
        if (dif.o_tx_start) restart_err++;
        if (dif.o_tx_data !== last_byte) unstable_err++;
      end
      dif.i_tx_done = 1'b0;
      dif.i_start   = 1'b0;
      if (cd > 0) begin
        cd--;
        dif.i_tx_done = (cd == 0);
      end else if (noise) begin
        dif.i_tx_done = 1'b1;
        dif.i_start   = 1'b1;
      end
      if (dif.o_tx_start) begin
        got_q.push_back(dif.o_tx_data);
        last_byte = dif.o_tx_data;
        cd = (got_q.size() - 1 == stall_at) ? stall_len : tx_delay;
        if (got_q.size() == reset_at) begin
          dif.i_tx_done = 1'b0;
          dif.i_start   = 1'b0;
          rst = 1'b1;
          timed_out = 1'b0;
          return;
        end
      end
      if (dif.o_done) begin
        ndone++;
        done_busy = dif.o_busy;
        timed_out = 1'b0;
        fin = 1;
        dif.i_tx_done = 1'b0;
        dif.i_start   = 1'b0;
      end
      tick();
      if (fin) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.i_start = 1'b0; dif.i_run = 1'b0; dif.i_tx_done = 1'b0; dif.i_pc_value = 7'h2A;
    repeat (3) tick();
    checks++; if (dif.o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b want=0", dif.o_tx_start); end
    checks++; if (dif.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", dif.o_tx_data); end
    checks++; if (dif.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", dif.o_busy); end
    checks++; if (dif.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", dif.o_done); end
    checks++; if ({dif.o_br_read, dif.o_dm_read} !== 2'b00) begin errors++; $display("FAIL reset_reads got=%b want=00", {dif.o_br_read, dif.o_dm_read}); end
    checks++; if ({dif.o_br_addr, dif.o_dm_addr} !== 12'h000) begin errors++; $display("FAIL reset_addrs got=%h want=000", {dif.o_br_addr, dif.o_dm_addr}); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_dump();
    bit to;
    int mism;
    dif.i_pc_value = 7'h2A;
    build_exp(7'h2A, 32'd0);
    run_dump(10, -1, 0, 1'b0, -1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b want=0", to); end
    checks++; if (busy_after_start !== 1'b1) begin errors++; $display("FAIL basic_busy_start got=%b want=1", busy_after_start); end
    checks++; if (got_q.size() != N_BYTES) begin errors++; $display("FAIL basic_bytes got=%0d want=%0d", got_q.size(), N_BYTES); end
    if (got_q.size() >= N_BYTES) begin
      checks++; if ({got_q[3], got_q[2], got_q[1], got_q[0]} !== 32'h0000_002A) begin errors++; $display("FAIL basic_pc got=%h want=0000002a", {got_q[3], got_q[2], got_q[1], got_q[0]}); end
      checks++; if ({got_q[4*REG_BASE+7], got_q[4*REG_BASE+6], got_q[4*REG_BASE+5], got_q[4*REG_BASE+4]} !== 32'h0000_0001) begin
        errors++; $display("FAIL basic_reg1 got=%h want=00000001", {got_q[4*REG_BASE+7], got_q[4*REG_BASE+6], got_q[4*REG_BASE+5], got_q[4*REG_BASE+4]}); end
      checks++; if ({got_q[N_BYTES-1], got_q[N_BYTES-2], got_q[N_BYTES-3], got_q[N_BYTES-4]} !== 32'h0000_00AF) begin
        errors++; $display("FAIL basic_last got=%h want=000000af", {got_q[N_BYTES-1], got_q[N_BYTES-2], got_q[N_BYTES-3], got_q[N_BYTES-4]}); end
    end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++; if (mism != 0) begin errors++; $display("FAIL basic_contents bad_bytes=%0d want=0", mism); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL basic_done_count got=%0d want=1", ndone); end
    checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b want=0", done_busy); end
    mism = 0;
    repeat (20) begin tick(); if (dif.o_done !== 1'b0 || dif.o_busy !== 1'b0) mism++; end
    checks++; if (mism != 0) begin errors++; $display("FAIL basic_idle_after bad_cycles=%0d want=0", mism); end
  endtask

  task automatic test_tx_stall();
    bit to;
    int mism;
    dif.i_pc_value = 7'h13;
    build_exp(7'h13, 32'd0);
    run_dump(3, 9, 1000, 1'b0, -1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout got=%b want=0", to); end
    checks++; if (restart_err != 0) begin errors++; $display("FAIL stall_restart got=%0d want=0", restart_err); end
    checks++; if (unstable_err != 0) begin errors++; $display("FAIL stall_data_hold got=%0d want=0", unstable_err); end
    checks++; if (got_q.size() != N_BYTES) begin errors++; $display("FAIL stall_bytes got=%0d want=%0d", got_q.size(), N_BYTES); end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++; if (mism != 0) begin errors++; $display("FAIL stall_contents bad_bytes=%0d want=0", mism); end
    repeat (3) tick();
  endtask

  task automatic test_ignored_inputs();
    bit to;
    int mism;
    dif.i_pc_value = 7'h7F;
    build_exp(7'h7F, 32'd0);
    run_dump(4, -1, 0, 1'b1, -1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL noise_timeout got=%b want=0", to); end
    checks++; if (got_q.size() != N_BYTES) begin errors++; $display("FAIL noise_bytes got=%0d want=%0d", got_q.size(), N_BYTES); end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++; if (mism != 0) begin errors++; $display("FAIL noise_contents bad_bytes=%0d want=0", mism); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL noise_done_count got=%0d want=1", ndone); end
    mism = 0;
    repeat (10) begin tick(); if (dif.o_busy !== 1'b0) mism++; end
    checks++; if (mism != 0) begin errors++; $display("FAIL noise_no_restart busy_cycles=%0d want=0", mism); end
  endtask

  task automatic test_reset_mid_dump();
    bit to;
    int seen;
    int mism;
    dif.i_pc_value = 7'h2A;
    run_dump(10, -1, 0, 1'b0, 50, to);
    checks++; if (rst !== 1'b1 || to !== 1'b0) begin errors++; $display("FAIL midreset_reached got_bytes=%0d want=50", got_q.size()); end
    tick();
    checks++; if ({dif.o_tx_start, dif.o_busy, dif.o_done, dif.o_br_read, dif.o_dm_read} !== 5'b0) begin
      errors++; $display("FAIL midreset_flags got=%b want=00000", {dif.o_tx_start, dif.o_busy, dif.o_done, dif.o_br_read, dif.o_dm_read}); end
    checks++; if ({dif.o_tx_data, dif.o_br_addr, dif.o_dm_addr} !== 20'h0) begin
      errors++; $display("FAIL midreset_buses got=%h want=00000", {dif.o_tx_data, dif.o_br_addr, dif.o_dm_addr}); end
    rst = 1'b0;
    seen = 0;
    repeat (30) begin tick(); if (dif.o_done !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_done got=%0d want=0", seen); end
    build_exp(7'h2A, 32'd0);
    run_dump(10, -1, 0, 1'b0, -1, to);
    checks++; if (got_q.size() != N_BYTES || to !== 1'b0) begin errors++; $display("FAIL midreset_redump_bytes got=%0d want=%0d", got_q.size(), N_BYTES); end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++; if (mism != 0) begin errors++; $display("FAIL midreset_redump_contents bad_bytes=%0d want=0", mism); end
    repeat (3) tick();
  endtask

  task automatic test_read_ports();
    bit to;
    int bad_br, bad_dm;
    run_dump(2, -1, 0, 1'b0, -1, to);
    bad_br = 0; bad_dm = 0;
    foreach (br_hits[i]) if (br_hits[i] != 1) bad_br++;
    foreach (dm_hits[i]) if (dm_hits[i] != 1) bad_dm++;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ports_timeout got=%b want=0", to); end
    checks++; if (bad_br != 0) begin errors++; $display("FAIL ports_br_once bad_regs=%0d want=0", bad_br); end
    checks++; if (bad_dm != 0) begin errors++; $display("FAIL ports_dm_once bad_words=%0d want=0", bad_dm); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL ports_overlap got=%0d want=0", overlap); end
    repeat (3) tick();
  endtask

`ifdef DUMP_CYCLE_COUNT_EN
  task automatic test_cycle_count();
    bit to;
    int mism;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dif.i_run = 1'b1;
    repeat (300) tick();
    dif.i_run = 1'b0;
    dif.i_pc_value = 7'h2A;
    build_exp(7'h2A, 32'd300);
    run_dump(3, -1, 0, 1'b0, -1, to);
    checks++; if (got_q.size() != N_BYTES || to !== 1'b0) begin errors++; $display("FAIL cyc_bytes got=%0d want=%0d", got_q.size(), N_BYTES); end
    if (got_q.size() >= 8) begin
      checks++; if ({got_q[7], got_q[6], got_q[5], got_q[4]} !== 32'h0000_012C) begin
        errors++; $display("FAIL cyc_word got=%h want=0000012c", {got_q[7], got_q[6], got_q[5], got_q[4]}); end
    end
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) mism++;
    checks++; if (mism != 0) begin errors++; $display("FAIL cyc_contents bad_bytes=%0d want=0", mism); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    dif.i_start = 1'b0;
    dif.i_run = 1'b0;
    dif.i_tx_done = 1'b0;
    dif.i_pc_value = '0;
    test_reset();
    test_basic_dump();
    test_tx_stall();
    test_ignored_inputs();
    test_reset_mid_dump();
    test_read_ports();
`ifdef DUMP_CYCLE_COUNT_EN
    test_cycle_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
